freq_meter: RTL
===============

# freq_meter

Gated frequency counter on the 50 MHz system clock. Synchronizes an asynchronous input, counts its rising edges over a fixed gate window (1 s by default), and reports the count in Hz with a one-cycle valid strobe. It recovers a frequency from a signal, where the clock divider produces one. Used to check divider outputs and external UART-side clocks on the board.

## Interface
- GATE_CYCLES, 50_000_000 — gate length in CLK_50M cycles (1 s at 50 MHz); minimum 2.
- CNT_W, 32 — width of edge counter and FREQ output.
- GC_W, 26 — width of gate counter; must satisfy 2^GC_W ≥ GATE_CYCLES.
- CLK_50M  input  1  system clock, 50 MHz, all logic on posedge.
- RST_N  input  1  synchronous reset, active-low.
- EN  input  1  run enable; level-sensitive.
- SIG_IN  input  1  asynchronous signal to measure.
- FREQ  output  CNT_W  rising-edge count of last completed gate; held between updates.
- VALID  output  1  one-cycle strobe; FREQ updated in the same cycle.
- BUSY  output  1  high while a gate window is in progress.
- OVF  output  1  last completed gate overflowed CNT_W (see Configuration).

## Operation
- Input path: SIG_IN → sync1 → sync2 → prev. rise = sync2 & ~prev. All three flops reset to 0.
- FSM states: IDLE, GATE.
  - IDLE: gate_cnt = 0, edge_cnt = 0, BUSY = 0. If EN = 1, go to GATE next cycle.
  - GATE: BUSY = 1; gate_cnt increments each cycle. edge_cnt increments on each cycle with rise = 1.
  - Gate closes on the cycle where gate_cnt == GATE_CYCLES-1. In that cycle, the final count is edge_cnt + rise.
  - On that closing edge: FREQ ← final count, OVF ← overflow flag, VALID ← 1 for one cycle. gate_cnt and edge_cnt clear.
  - After close: if EN = 1, stay in GATE and start the next window back-to-back with no dead cycle. If EN = 0, go to IDLE.
- EN deasserted mid-gate: abort. Go to IDLE next cycle, discard counts, no VALID, FREQ/OVF keep their last values.
- Edges are counted only in GATE. Edges present in IDLE are ignored.
- A steady-high SIG_IN at reset release produces one rise, 3 cycles later. It is ignored if the FSM is still in IDLE.
- Max measurable frequency is CLK_50M/2 (SIG_IN toggling every cycle). Above that, aliasing occurs; this is not flagged.

## Timing
- Reset values: FREQ = 0, VALID = 0, BUSY = 0, OVF = 0, state = IDLE, all counters and sync flops 0.
- EN rising at edge k: BUSY = 1 from edge k+1. The first gate cycle is k+1.
- A SIG_IN rising transition is counted in the cycle 2–3 clocks after it occurs (synchronizer latency).
- Window = exactly GATE_CYCLES cycles. VALID rises at the edge after the last gate cycle, i.e. GATE_CYCLES cycles after BUSY rose.
- In continuous mode, consecutive VALID strobes are exactly GATE_CYCLES cycles apart.
- Reset overrides everything. RST_N low mid-gate returns all outputs to reset values on the next edge.

## Configuration
- FREQ_METER_OVF_EN defined:
  - edge_cnt saturates at 2^CNT_W−1.
  - A sticky per-window flag is set when an increment is attempted at the saturated value.
  - At gate close, OVF ← flag and FREQ = all-ones.
- FREQ_METER_OVF_EN undefined:
  - edge_cnt wraps modulo 2^CNT_W.
  - OVF is tied to 0.
  - No saturation logic is synthesized.

## Test plan
- GATE_CYCLES = 1000, SIG_IN = 5 MHz square wave (period 10 clocks), EN held high → VALID every 1000 cycles, FREQ = 100, OVF = 0.
- GATE_CYCLES = 1000, SIG_IN toggling every clock (25 MHz) → FREQ = 500. SIG_IN held constant 0 or 1 → FREQ = 0.
- CNT_W = 4, GATE_CYCLES = 1000, 5 MHz input → with FREQ_METER_OVF_EN: FREQ = 15, OVF = 1. Without it: FREQ = 4, OVF = 0.
- Complete one window (FREQ = 100), then drop EN at gate cycle 500 → BUSY falls next cycle, no VALID, FREQ stays 100. Re-raise EN → next window reports 100 again.
- Reset at gate cycle 300 of a running window → next cycle FREQ = 0, VALID = 0, BUSY = 0, OVF = 0. EN held high after release → first VALID exactly 1001 cycles after RST_N returns high.
- Pulse SIG_IN high for 3 clocks, starting 1 cycle before the last gate cycle → edge lands in the next window (synchronizer latency). Current FREQ excludes it; next FREQ includes it.

Source files
------------

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter. Counts synchronized SIG_IN rising edges over GATE_CYCLES clocks.
// Optional macro FREQ_METER_OVF_EN: saturating edge counter with a per-window overflow flag on OVF.
module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 32,
   parameter int GC_W        = 26
) (
   input  logic             CLK_50M,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             SIG_IN,
   output logic [CNT_W-1:0] FREQ,
   output logic             VALID,
   output logic             BUSY,
   output logic             OVF
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_GATE = 1'b1
   } state_t;

   localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             prev_r;
   logic             rise_s;
   logic             gate_done_s;
   state_t           state_r;
   logic [GC_W-1:0]  gate_cnt_r;
   logic [CNT_W-1:0] edge_cnt_r;
   logic [CNT_W-1:0] edge_next_s;
   logic             ovf_next_s;
   logic [CNT_W-1:0] freq_r;
   logic             valid_r;
   logic             busy_r;
   logic             ovf_r;

   assign rise_s      = sync2_r & ~prev_r;
   assign gate_done_s = (state_r == ST_GATE) && (gate_cnt_r == GATE_LAST);

`ifdef FREQ_METER_OVF_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic ovf_flag_r;

   // Saturating edge count; an increment attempted at the ceiling marks the window as overflowed.
   always_comb begin
      edge_next_s = edge_cnt_r;
      ovf_next_s  = ovf_flag_r;
      if (rise_s && (edge_cnt_r == CNT_MAX)) begin
         ovf_next_s = 1'b1;
      end else if (rise_s) begin
         edge_next_s = edge_cnt_r + CNT_W'(1'b1);
      end else begin
         edge_next_s = edge_cnt_r;
      end
   end

   // Sticky overflow flag, live only inside a running window.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         ovf_flag_r <= 1'b0;
      end else if ((state_r == ST_GATE) && EN && !gate_done_s) begin
         ovf_flag_r <= ovf_next_s;
      end else begin
         ovf_flag_r <= 1'b0;
      end
   end
`else
   // Wrapping edge count; no overflow reporting in this build.
   always_comb begin
      edge_next_s = edge_cnt_r + CNT_W'(rise_s);
      ovf_next_s  = 1'b0;
   end
`endif

   // Two-flop synchronizer plus delayed copy for rising-edge detection.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= SIG_IN;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Gate FSM; the closing cycle folds in its own rise so back-to-back windows lose no edge.
   always_ff @(posedge CLK_50M) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         gate_cnt_r <= '0;
         edge_cnt_r <= '0;
         freq_r     <= '0;
         valid_r    <= 1'b0;
         busy_r     <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               gate_cnt_r <= '0;
               edge_cnt_r <= '0;
               if (EN) begin
                  state_r <= ST_GATE;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_GATE: begin
               if (gate_done_s) begin
                  freq_r     <= edge_next_s;
                  ovf_r      <= ovf_next_s;
                  valid_r    <= 1'b1;
                  gate_cnt_r <= '0;
                  edge_cnt_r <= '0;
                  if (EN) begin
                     state_r <= ST_GATE;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (!EN) begin
                  state_r    <= ST_IDLE;
                  busy_r     <= 1'b0;
                  gate_cnt_r <= '0;
                  edge_cnt_r <= '0;
               end else begin
                  gate_cnt_r <= gate_cnt_r + GC_W'(1'b1);
                  edge_cnt_r <= edge_next_s;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               gate_cnt_r <= '0;
               edge_cnt_r <= '0;
            end
         endcase
      end
   end

   assign FREQ  = freq_r;
   assign VALID = valid_r;
   assign BUSY  = busy_r;
   assign OVF   = ovf_r;

endmodule
